// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    localparam int unsigned MAX_STEPS  = 8;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned CFG_ADDR_W = 4;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned PIO_ADDR_W = 2;

    localparam logic [CFG_ADDR_W-1:0] ADDR_CTRL     = 4'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_PERIOD   = 4'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_STATUS   = 4'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_PAT_BASE = 4'd8;

    localparam int unsigned EN      = 0;
    localparam int unsigned ONESHOT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // STATUS register layout
    typedef struct packed {
        logic [22:0]       rsvd_hi;
        logic              done;
        logic              rsvd_7;
        logic [STEP_W-1:0] step;
        logic [2:0]        rsvd_lo;
        logic              busy;
    } status_t;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM bus bundle; one instance for the config slave, one for the PIO master.
interface led_pattern_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = CFG_ADDR_W,
    parameter int unsigned DATA_W = CFG_DATA_W
);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/led_seq_regs.sv
// Config register file, pattern table and zero-wait read mux.
module led_seq_regs
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PERIOD_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CFG_ADDR_W-1:0] address_i,
    input  logic                  chipselect_i,
    input  logic                  write_n_i,
    input  logic [CFG_DATA_W-1:0] writedata_i,
    output logic [CFG_DATA_W-1:0] rdata_c_o,
    input  logic                  busy_i,
    input  logic [STEP_W-1:0]     step_i,
    input  logic                  fsm_done_i,
    input  logic [STEP_W-1:0]     pat_sel_i,
    output logic                  en_o,
    output logic                  oneshot_o,
    output logic [PERIOD_W-1:0]   period_o,
    output logic [DATA_W-1:0]     pat_c_o
);

    logic                en_q;
    logic                oneshot_q;
    logic                done_q;
    logic [PERIOD_W-1:0] period_q;
    logic [DATA_W-1:0]   pat_q [MAX_STEPS];

    logic                  wr_c;
    logic                  pat_hit_c;
    logic [STEP_W-1:0]     pat_idx_c;
    logic [CFG_DATA_W-1:0] ctrl_c;
    status_t               status_c;

    assign wr_c      = chipselect_i && !write_n_i;
    assign pat_hit_c = (address_i >= ADDR_PAT_BASE) &&
                       (32'(address_i) < 32'(ADDR_PAT_BASE) + NUM_STEPS);
    assign pat_idx_c = address_i[STEP_W-1:0];

    // FSM completion is applied last so it overrides a same-cycle CTRL write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
            period_q  <= '0;
            for (int i = 0; i < int'(MAX_STEPS); i++) begin
                pat_q[i] <= '0;
            end
        end else begin
            if (wr_c && address_i == ADDR_CTRL) begin
                en_q      <= writedata_i[EN];
                oneshot_q <= writedata_i[ONESHOT];
                done_q    <= 1'b0;
            end
            if (wr_c && address_i == ADDR_PERIOD) begin
                period_q <= writedata_i[PERIOD_W-1:0];
            end
            if (wr_c && pat_hit_c) begin
                pat_q[pat_idx_c] <= writedata_i[DATA_W-1:0];
            end
            if (fsm_done_i) begin
                en_q   <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_c          = '0;
        ctrl_c[EN]      = en_q;
        ctrl_c[ONESHOT] = oneshot_q;
        status_c        = '0;
        status_c.busy   = busy_i;
        status_c.step   = step_i;
        status_c.done   = done_q;
        rdata_c_o       = '0;
        if (address_i == ADDR_CTRL) begin
            rdata_c_o = ctrl_c;
        end else if (address_i == ADDR_PERIOD) begin
            rdata_c_o = CFG_DATA_W'(period_q);
        end else if (address_i == ADDR_STATUS) begin
            rdata_c_o = status_c;
        end else if (pat_hit_c) begin
            rdata_c_o = CFG_DATA_W'(pat_q[pat_idx_c]);
        end
    end

    assign en_o      = en_q;
    assign oneshot_o = oneshot_q;
    assign period_o  = period_q;
    assign pat_c_o   = pat_q[pat_sel_i];

endmodule

// File: rtl/led_pattern_sequencer.sv
// Replays a small pattern table onto the LED PIO at a programmable period.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PERIOD_W  = 32
) (
    input  logic clk,
    input  logic reset_n,
    led_pattern_sequencer_if.slave  cfg,
    led_pattern_sequencer_if.master pio
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                wr_n_q;

    logic                en_c;
    logic                oneshot_c;
    logic [PERIOD_W-1:0] period_c;
    logic [DATA_W-1:0]   pat_c;
    logic                busy_c;
    logic                last_c;
    logic                fsm_done_c;
    logic [STEP_W-1:0]   step_nxt_c;
    logic [STEP_W-1:0]   pat_sel_c;
    logic                unused_pio_c;

    led_seq_regs #(
        .NUM_STEPS (NUM_STEPS),
        .DATA_W    (DATA_W),
        .PERIOD_W  (PERIOD_W)
    ) u_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_i    (cfg.address),
        .chipselect_i (cfg.chipselect),
        .write_n_i    (cfg.write_n),
        .writedata_i  (cfg.writedata),
        .rdata_c_o    (cfg.readdata),
        .busy_i       (busy_c),
        .step_i       (step_q),
        .fsm_done_i   (fsm_done_c),
        .pat_sel_i    (pat_sel_c),
        .en_o         (en_c),
        .oneshot_o    (oneshot_c),
        .period_o     (period_c),
        .pat_c_o      (pat_c)
    );

    assign busy_c     = (state_q != IDLE);
    assign last_c     = (step_q == STEP_W'(NUM_STEPS - 1));
    assign step_nxt_c = last_c ? '0 : step_q + 1'b1;
    // IDLE starts at the current step; WAIT fetches the word for the step it advances to
    assign pat_sel_c  = (state_q == IDLE) ? step_q : step_nxt_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            cs_q    <= cs_d;
            wr_n_q  <= !cs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        fsm_done_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_c) begin
                    wdata_d = pat_c;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!pio.waitrequest) begin
                    if (en_c) begin
                        cnt_d   = (period_c == '0) ? '0 : period_c - 1'b1;
                        state_d = WAIT;
                    end else begin
                        // disabled mid-transfer: the word went out, so move past it
                        state_d = IDLE;
                        if (last_c && oneshot_c) begin
                            fsm_done_c = 1'b1;
                            step_d     = '0;
                        end else begin
                            step_d = step_nxt_c;
                        end
                    end
                end
            end
            WAIT: begin
                if (!en_c) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (last_c && oneshot_c) begin
                        fsm_done_c = 1'b1;
                        step_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        step_d  = step_nxt_c;
                        wdata_d = pat_c;
                        state_d = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cs_d = (state_d == WRITE);
    end

    assign pio.address    = '0;
    assign pio.chipselect = cs_q;
    assign pio.write_n    = wr_n_q;
    assign pio.writedata  = wdata_q;
    assign cfg.waitrequest = 1'b0;
    assign unused_pio_c   = ^pio.readdata;

endmodule
